// File: rtl/memory_access_pkg.sv
// Shared types for the memory access stage: access sizes, FSM states,
// byte-mask and alignment helpers.
package memory_access_pkg;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_t;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_REQ       = 2'd1;
  localparam logic [1:0] S_RESP_HOLD = 2'd2;

  function automatic logic [7:0] size_mask(msize_t s);
    logic [7:0] m;
    unique case (s)
      MSIZE_B: m = 8'h01;
      MSIZE_H: m = 8'h03;
      MSIZE_W: m = 8'h0F;
      MSIZE_D: m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic is_aligned(msize_t s, logic [2:0] a);
    logic ok;
    unique case (s)
      MSIZE_B: ok = 1'b1;
      MSIZE_H: ok = (a[0] == 1'b0);
      MSIZE_W: ok = (a[1:0] == 2'b00);
      MSIZE_D: ok = (a == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// Selects the addressed lanes of a raw aligned bus word and
// sign- or zero-extends them to the full datapath width.
module load_extend
  import memory_access_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      offset,
  input  msize_t          size,
  input  logic            sig,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  assign shifted = raw >> {offset, 3'b000};

  always_comb begin
    result = '0;
    unique case (size)
      MSIZE_B: result = {{(XLEN-8){sig & shifted[7]}}, shifted[7:0]};
      MSIZE_H: result = {{(XLEN-16){sig & shifted[15]}}, shifted[15:0]};
      MSIZE_W: result = {{(XLEN-32){sig & shifted[31]}}, shifted[31:0]};
      MSIZE_D: result = shifted;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory access pipeline stage: issues loads/stores on the dbus,
// extends load data and hands a one-cycle pulse to writeback.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            execute_valid,
  input  logic [31:0]     reg_execute_ins,
  input  logic [63:0]     reg_execute_pc,
  input  logic [4:0]      reg_execute_rd,
  input  logic            reg_execute_mem_r,
  input  logic            reg_execute_mem_w,
  input  logic            reg_execute_reg_w,
  input  msize_t          reg_execute_msize,
  input  logic            reg_execute_sig,
  input  logic [XLEN-1:0] reg_execute_data_out,
  input  logic [XLEN-1:0] reg_execute_rd2,
  input  logic [63:0]     reg_execute_csr_data_out,
  input  logic            stall,
  output logic            dreq_valid,
  output logic [63:0]     dreq_addr,
  output msize_t          dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            memory_valid,
  output logic [31:0]     reg_memory_ins,
  output logic [63:0]     reg_memory_pc,
  output logic [4:0]      reg_memory_rd,
  output logic            reg_memory_reg_w,
  output logic [63:0]     reg_memory_csr_data_out,
  output logic [XLEN-1:0] reg_memory_data_out,
  output logic            memory_stall,
  output logic            mem_error
);

  logic [1:0]      state;
  logic            mem_r;
  logic            mem_w;
  msize_t          msize;
  logic            sig;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] rd2;
  logic [31:0]     wait_cnt;
  logic            timeout_hit;
  logic [XLEN-1:0] load_result;
  logic            ev_mem;
  logic            ev_aligned;

  assign ev_mem     = reg_execute_mem_r | reg_execute_mem_w;
  assign ev_aligned = is_aligned(reg_execute_msize,
                                 reg_execute_data_out[2:0]);

  assign timeout_hit = (TIMEOUT > 0) &&
                       (wait_cnt >= 32'(TIMEOUT - 1));

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .raw    (dresp_data),
    .offset (addr[2:0]),
    .size   (msize),
    .sig    (sig),
    .result (load_result)
  );

  assign dreq_valid  = (state == S_REQ);
  assign dreq_addr   = dreq_valid ? 64'(addr) : '0;
  assign dreq_size   = dreq_valid ? msize : MSIZE_B;
  assign dreq_strobe = (dreq_valid && mem_w) ?
                       (size_mask(msize) << addr[2:0]) : '0;
  assign dreq_data   = (dreq_valid && mem_w) ?
                       (rd2 << {addr[2:0], 3'b000}) : '0;

  assign memory_stall = (state == S_REQ) ||
                        ((state == S_RESP_HOLD) && stall);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                   <= S_IDLE;
      mem_r                   <= 1'b0;
      mem_w                   <= 1'b0;
      msize                   <= MSIZE_B;
      sig                     <= 1'b0;
      addr                    <= '0;
      rd2                     <= '0;
      wait_cnt                <= '0;
      memory_valid            <= 1'b0;
      reg_memory_ins          <= '0;
      reg_memory_pc           <= '0;
      reg_memory_rd           <= '0;
      reg_memory_reg_w        <= 1'b0;
      reg_memory_csr_data_out <= '0;
      reg_memory_data_out     <= '0;
      mem_error               <= 1'b0;
    end else begin
      memory_valid <= 1'b0;
      unique case (1'b1)
        state == S_IDLE: begin
          if (execute_valid) begin
            mem_r                   <= reg_execute_mem_r;
            mem_w                   <= reg_execute_mem_w;
            msize                   <= reg_execute_msize;
            sig                     <= reg_execute_sig;
            addr                    <= reg_execute_data_out;
            rd2                     <= reg_execute_rd2;
            wait_cnt                <= '0;
            reg_memory_ins          <= reg_execute_ins;
            reg_memory_pc           <= reg_execute_pc;
            reg_memory_rd           <= reg_execute_rd;
            reg_memory_reg_w        <= reg_execute_reg_w;
            reg_memory_csr_data_out <= reg_execute_csr_data_out;
            reg_memory_data_out     <= reg_execute_data_out;
            mem_error               <= 1'b0;
            if (ev_mem && ev_aligned) begin
              state <= S_REQ;
            end else begin
              state <= S_RESP_HOLD;
              if (ev_mem) begin
                mem_error        <= 1'b1;
                reg_memory_reg_w <= 1'b0;
              end
            end
          end
        end
        state == S_REQ: begin
          if (dresp_data_ok) begin
            if (mem_r) reg_memory_data_out <= load_result;
            state <= S_RESP_HOLD;
          end else if (timeout_hit) begin
            mem_error        <= 1'b1;
            reg_memory_reg_w <= 1'b0;
            state            <= S_RESP_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        state == S_RESP_HOLD: begin
          if (!stall) begin
            memory_valid <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A new execute bundle may only arrive while the stage is idle.
  a_ev_only_idle: assert property (
    @(posedge clk) disable iff (!rst)
    !(execute_valid && (state != S_IDLE))
  );

endmodule

// File: tb/tb_memory_access.sv
// Directed testbench for memory_access: loads, stores, misalignment,
// stall hold, back-to-back ops and reset during a bus request.
module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk;
  logic        rst;
  logic        execute_valid;
  logic [31:0] reg_execute_ins;
  logic [63:0] reg_execute_pc;
  logic [4:0]  reg_execute_rd;
  logic        reg_execute_mem_r;
  logic        reg_execute_mem_w;
  logic        reg_execute_reg_w;
  msize_t      reg_execute_msize;
  logic        reg_execute_sig;
  logic [63:0] reg_execute_data_out;
  logic [63:0] reg_execute_rd2;
  logic [63:0] reg_execute_csr_data_out;
  logic        stall;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  msize_t      dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        memory_valid;
  logic [31:0] reg_memory_ins;
  logic [63:0] reg_memory_pc;
  logic [4:0]  reg_memory_rd;
  logic        reg_memory_reg_w;
  logic [63:0] reg_memory_csr_data_out;
  logic [63:0] reg_memory_data_out;
  logic        memory_stall;
  logic        mem_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  memory_access #(.XLEN(64), .TIMEOUT(0)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .execute_valid            (execute_valid),
    .reg_execute_ins          (reg_execute_ins),
    .reg_execute_pc           (reg_execute_pc),
    .reg_execute_rd           (reg_execute_rd),
    .reg_execute_mem_r        (reg_execute_mem_r),
    .reg_execute_mem_w        (reg_execute_mem_w),
    .reg_execute_reg_w        (reg_execute_reg_w),
    .reg_execute_msize        (reg_execute_msize),
    .reg_execute_sig          (reg_execute_sig),
    .reg_execute_data_out     (reg_execute_data_out),
    .reg_execute_rd2          (reg_execute_rd2),
    .reg_execute_csr_data_out (reg_execute_csr_data_out),
    .stall                    (stall),
    .dreq_valid               (dreq_valid),
    .dreq_addr                (dreq_addr),
    .dreq_size                (dreq_size),
    .dreq_strobe              (dreq_strobe),
    .dreq_data                (dreq_data),
    .dresp_data_ok            (dresp_data_ok),
    .dresp_data               (dresp_data),
    .memory_valid             (memory_valid),
    .reg_memory_ins           (reg_memory_ins),
    .reg_memory_pc            (reg_memory_pc),
    .reg_memory_rd            (reg_memory_rd),
    .reg_memory_reg_w         (reg_memory_reg_w),
    .reg_memory_csr_data_out  (reg_memory_csr_data_out),
    .reg_memory_data_out      (reg_memory_data_out),
    .memory_stall             (memory_stall),
    .mem_error                (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at a negedge; raises execute_valid for one cycle.
  task automatic drive_op(
    input logic [31:0] ins, input logic [63:0] pc,
    input logic [4:0] rd, input logic mr, input logic mw,
    input logic rw, input msize_t sz, input logic sg,
    input logic [63:0] dout, input logic [63:0] r2,
    input logic [63:0] csr, output int t0);
    reg_execute_ins          = ins;
    reg_execute_pc           = pc;
    reg_execute_rd           = rd;
    reg_execute_mem_r        = mr;
    reg_execute_mem_w        = mw;
    reg_execute_reg_w        = rw;
    reg_execute_msize        = sz;
    reg_execute_sig          = sg;
    reg_execute_data_out     = dout;
    reg_execute_rd2          = r2;
    reg_execute_csr_data_out = csr;
    execute_valid            = 1'b1;
    t0 = cyc;
    @(negedge clk);
    execute_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int t0, output int lat,
                            output bit seen);
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 20; i++) begin
      if (memory_valid) begin
        seen = 1'b1;
        lat  = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dreq_valid, memory_valid, mem_error, memory_stall,
         reg_memory_reg_w} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {dreq_valid, memory_valid, mem_error,
                memory_stall, reg_memory_reg_w});
    end
    checks++;
    if (reg_memory_data_out !== 64'h0 || reg_memory_pc !== 64'h0 ||
        dreq_strobe !== 8'h0 || dreq_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: data_out %h pc %h strobe %h addr %h want 0",
               reg_memory_data_out, reg_memory_pc, dreq_strobe,
               dreq_addr);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ld();
    int t0, lat;
    bit seen;
    drive_op(32'h0000_3003, 64'h8000_0010, 5'd7, 1'b1, 1'b0, 1'b1,
             MSIZE_D, 1'b1, 64'h1000, 64'h0, 64'hC5, t0);
    checks++;
    if (dreq_valid !== 1'b1 || dreq_addr !== 64'h1000 ||
        dreq_strobe !== 8'h00 || dreq_size !== MSIZE_D ||
        memory_stall !== 1'b1) begin
      errors++;
      $display("FAIL ld_req: valid %b addr %h strobe %h size %0d stall %b want 1 1000 00 3 1",
               dreq_valid, dreq_addr, dreq_strobe, dreq_size,
               memory_stall);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dreq_valid !== 1'b1 || dreq_addr !== 64'h1000) begin
      errors++;
      $display("FAIL ld_req_hold: valid %b addr %h want 1 1000",
               dreq_valid, dreq_addr);
    end
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h8000_0000_0000_0001;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    dresp_data    = 64'h0;
    checks++;
    if (dreq_valid !== 1'b0) begin
      errors++;
      $display("FAIL ld_req_drop: dreq_valid %b want 0", dreq_valid);
    end
    wait_pulse(t0, lat, seen);
    checks++;
    if (!seen || lat != 5) begin
      errors++;
      $display("FAIL ld_latency: seen %b lat %0d want 1 5", seen, lat);
    end
    checks++;
    if (reg_memory_data_out !== 64'h8000_0000_0000_0001 ||
        reg_memory_rd !== 5'd7 || reg_memory_reg_w !== 1'b1 ||
        reg_memory_pc !== 64'h8000_0010 ||
        reg_memory_ins !== 32'h0000_3003 ||
        reg_memory_csr_data_out !== 64'hC5 ||
        mem_error !== 1'b0) begin
      errors++;
      $display("FAIL ld_bundle: data %h rd %0d rw %b pc %h ins %h csr %h err %b",
               reg_memory_data_out, reg_memory_rd, reg_memory_reg_w,
               reg_memory_pc, reg_memory_ins,
               reg_memory_csr_data_out, mem_error);
    end
    @(negedge clk);
    checks++;
    if (memory_valid !== 1'b0) begin
      errors++;
      $display("FAIL ld_single_pulse: memory_valid %b want 0",
               memory_valid);
    end
  endtask

  task automatic test_lb(input logic sg, input logic [63:0] want);
    int t0, lat;
    bit seen;
    drive_op(32'h0000_0003, 64'h100, 5'd9, 1'b1, 1'b0, 1'b1,
             MSIZE_B, sg, 64'h1003, 64'h0, 64'h0, t0);
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h0000_0000_FF00_0000;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    dresp_data    = 64'h0;
    wait_pulse(t0, lat, seen);
    checks++;
    if (!seen || lat != 3 || reg_memory_data_out !== want) begin
      errors++;
      $display("FAIL lb_sig%0d: seen %b lat %0d data %h want 1 3 %h",
               sg, seen, lat, reg_memory_data_out, want);
    end
    @(negedge clk);
  endtask

  task automatic test_sh();
    int t0, lat;
    bit seen;
    drive_op(32'h0000_1023, 64'h200, 5'd0, 1'b0, 1'b1, 1'b0,
             MSIZE_H, 1'b0, 64'h2006, 64'h1234, 64'h0, t0);
    checks++;
    if (dreq_valid !== 1'b1 || dreq_strobe !== 8'hC0 ||
        dreq_data !== 64'h1234_0000_0000_0000 ||
        dreq_size !== MSIZE_H || dreq_addr !== 64'h2006) begin
      errors++;
      $display("FAIL sh_req: valid %b strobe %h data %h size %0d addr %h",
               dreq_valid, dreq_strobe, dreq_data, dreq_size,
               dreq_addr);
    end
    dresp_data_ok = 1'b1;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    wait_pulse(t0, lat, seen);
    checks++;
    if (!seen || lat != 3 || reg_memory_data_out !== 64'h2006 ||
        reg_memory_reg_w !== 1'b0) begin
      errors++;
      $display("FAIL sh_done: seen %b lat %0d data %h rw %b want 1 3 2006 0",
               seen, lat, reg_memory_data_out, reg_memory_reg_w);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    int t0, lat;
    bit seen;
    drive_op(32'h0000_2003, 64'h300, 5'd4, 1'b1, 1'b0, 1'b1,
             MSIZE_W, 1'b1, 64'h1002, 64'h0, 64'h0, t0);
    checks++;
    if (dreq_valid !== 1'b0 || mem_error !== 1'b1) begin
      errors++;
      $display("FAIL lw_misaligned: dreq_valid %b mem_error %b want 0 1",
               dreq_valid, mem_error);
    end
    wait_pulse(t0, lat, seen);
    checks++;
    if (!seen || lat != 2 || reg_memory_reg_w !== 1'b0 ||
        reg_memory_data_out !== 64'h1002) begin
      errors++;
      $display("FAIL lw_mis_done: seen %b lat %0d rw %b data %h want 1 2 0 1002",
               seen, lat, reg_memory_reg_w, reg_memory_data_out);
    end
    @(negedge clk);
    checks++;
    if (mem_error !== 1'b1) begin
      errors++;
      $display("FAIL lw_err_sticky: mem_error %b want 1", mem_error);
    end
  endtask

  task automatic test_stall();
    int t0, lat, bad;
    bit seen;
    stall = 1'b1;
    drive_op(32'h00B5_0533, 64'h400, 5'd10, 1'b0, 1'b0, 1'b1,
             MSIZE_D, 1'b0, 64'hABCD, 64'h0, 64'h0, t0);
    checks++;
    if (mem_error !== 1'b0) begin
      errors++;
      $display("FAIL add_err_clear: mem_error %b want 0", mem_error);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (memory_valid !== 1'b0 || memory_stall !== 1'b1 ||
          reg_memory_data_out !== 64'hABCD ||
          reg_memory_rd !== 5'd10)
        bad++;
      if (i == 3) stall = 1'b0;
      else @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL add_stall_hold: %0d bad cycles want 0", bad);
    end
    @(negedge clk);
    wait_pulse(t0, lat, seen);
    checks++;
    if (!seen || lat != 5 || reg_memory_data_out !== 64'hABCD) begin
      errors++;
      $display("FAIL add_stall_pulse: seen %b lat %0d data %h want 1 5 abcd",
               seen, lat, reg_memory_data_out);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (memory_valid) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL add_one_pulse: %0d extra pulses want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, lat;
    bit seen;
    drive_op(32'h13, 64'h500, 5'd1, 1'b0, 1'b0, 1'b1,
             MSIZE_D, 1'b0, 64'h1111, 64'h0, 64'h0, t0);
    wait_pulse(t0, lat, seen);
    checks++;
    if (!seen || lat != 2 || reg_memory_data_out !== 64'h1111) begin
      errors++;
      $display("FAIL b2b_first: seen %b lat %0d data %h want 1 2 1111",
               seen, lat, reg_memory_data_out);
    end
    drive_op(32'h13, 64'h504, 5'd2, 1'b0, 1'b0, 1'b1,
             MSIZE_D, 1'b0, 64'h2222, 64'h0, 64'h0, t1);
    wait_pulse(t1, lat, seen);
    checks++;
    if (!seen || lat != 2 || reg_memory_data_out !== 64'h2222 ||
        reg_memory_rd !== 5'd2) begin
      errors++;
      $display("FAIL b2b_second: seen %b lat %0d data %h rd %0d want 1 2 2222 2",
               seen, lat, reg_memory_data_out, reg_memory_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    int t0, lat, bad;
    bit seen;
    drive_op(32'h3003, 64'h600, 5'd3, 1'b1, 1'b0, 1'b1,
             MSIZE_D, 1'b0, 64'h3000, 64'h0, 64'h77, t0);
    checks++;
    if (dreq_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_req_start: dreq_valid %b want 1", dreq_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dreq_valid, memory_valid, memory_stall, mem_error,
         reg_memory_reg_w} !== 5'b0 ||
        reg_memory_pc !== 64'h0 || reg_memory_data_out !== 64'h0 ||
        reg_memory_csr_data_out !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_req: flags %b pc %h data %h csr %h want 0",
               {dreq_valid, memory_valid, memory_stall, mem_error,
                reg_memory_reg_w}, reg_memory_pc,
               reg_memory_data_out, reg_memory_csr_data_out);
    end
    rst = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = 64'hDEAD_BEEF_0000_0000;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    dresp_data    = 64'h0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (memory_valid || dreq_valid || memory_stall) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_late_ok: %0d active cycles want 0", bad);
    end
    drive_op(32'h33, 64'h700, 5'd5, 1'b0, 1'b0, 1'b1,
             MSIZE_D, 1'b0, 64'h55, 64'h0, 64'h0, t0);
    wait_pulse(t0, lat, seen);
    checks++;
    if (!seen || lat != 2 || reg_memory_data_out !== 64'h55 ||
        reg_memory_reg_w !== 1'b1) begin
      errors++;
      $display("FAIL rst_next_op: seen %b lat %0d data %h rw %b want 1 2 55 1",
               seen, lat, reg_memory_data_out, reg_memory_reg_w);
    end
    @(negedge clk);
  endtask

  initial begin
    rst                      = 1'b0;
    execute_valid            = 1'b0;
    reg_execute_ins          = '0;
    reg_execute_pc           = '0;
    reg_execute_rd           = '0;
    reg_execute_mem_r        = 1'b0;
    reg_execute_mem_w        = 1'b0;
    reg_execute_reg_w        = 1'b0;
    reg_execute_msize        = MSIZE_B;
    reg_execute_sig          = 1'b0;
    reg_execute_data_out     = '0;
    reg_execute_rd2          = '0;
    reg_execute_csr_data_out = '0;
    stall                    = 1'b0;
    dresp_data_ok            = 1'b0;
    dresp_data               = '0;
    test_reset();
    test_ld();
    test_lb(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    test_lb(1'b0, 64'h0000_0000_0000_00FF);
    test_sh();
    test_misaligned();
    test_stall();
    test_back_to_back();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
